// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the microsequencer (master) and the
// multi-cycle shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int WIDTH    = 32,
  parameter int AMOUNT_W = 5
);
  logic                start;
  logic                op;
  logic [AMOUNT_W-1:0] amount;
  logic [WIDTH-1:0]    data_in;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    result;

  modport master (
    output start, op, amount, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, op, amount, data_in,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterates the single-step MIC-1 shifter a counted number of passes, feeding each
// result back through the accumulator, and hands the final word back via start/busy/done.
module shift_sequencer #(
  parameter int WIDTH           = 32,
  parameter int AMOUNT_W        = 5,
  parameter int MAX_LEFT_PASSES = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus,
  output logic [1:0]       sh_control,
  output logic [WIDTH-1:0] sh_data,
  input  logic [WIDTH-1:0] sh_result
);

  localparam logic [1:0] CTRL_PASS  = 2'b00;
  localparam logic [1:0] CTRL_RIGHT = 2'b01;
  localparam logic [1:0] CTRL_LEFT  = 2'b10;

  localparam logic [AMOUNT_W-1:0] LEFT_CAP = AMOUNT_W'(MAX_LEFT_PASSES);
  localparam logic [AMOUNT_W-1:0] ONE      = AMOUNT_W'(1);
  localparam logic [AMOUNT_W-1:0] ZERO     = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    acc;
  logic [AMOUNT_W-1:0] cnt;
  logic                op_q;
  logic [AMOUNT_W-1:0] passes;

  // Left passes beyond WIDTH/8 only push zeros, so they are clipped away.
  always_comb begin
    passes = bus.amount;
    if (!bus.op && (bus.amount > LEFT_CAP)) begin
      passes = LEFT_CAP;
    end
  end

  assign sh_data = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      op_q       <= 1'b0;
      bus.result <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      sh_control <= CTRL_PASS;
    end else begin
      case (state)
        IDLE: begin
          bus.done   <= 1'b0;
          sh_control <= CTRL_PASS;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (passes == ZERO) begin
              bus.result <= bus.data_in;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              acc        <= bus.data_in;
              cnt        <= passes;
              op_q       <= bus.op;
              sh_control <= bus.op ? CTRL_RIGHT : CTRL_LEFT;
              state      <= SHIFT;
            end
          end
        end

        // The last pass lands straight in result so done and result line up.
        SHIFT: begin
          acc <= sh_result;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            bus.result <= sh_result;
            bus.done   <= 1'b1;
            sh_control <= CTRL_PASS;
            state      <= DONE;
          end else begin
            sh_control <= op_q ? CTRL_RIGHT : CTRL_LEFT;
          end
        end

        DONE: begin
          bus.done   <= 1'b0;
          bus.busy   <= 1'b0;
          sh_control <= CTRL_PASS;
          state      <= IDLE;
        end

        default: begin
          bus.done   <= 1'b0;
          bus.busy   <= 1'b0;
          sh_control <= CTRL_PASS;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, hand-written
// abort/back-to-back sequences and random operations against a plain-arithmetic model.
module tb_shift_sequencer;

  localparam int WIDTH    = 32;
  localparam int AMOUNT_W = 5;

  logic             clk;
  logic             reset;
  logic [1:0]       sh_control;
  logic [WIDTH-1:0] sh_data;
  logic [WIDTH-1:0] sh_result;

  int compared;
  int mismatched;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMOUNT_W(AMOUNT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMOUNT_W(AMOUNT_W), .MAX_LEFT_PASSES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sh_control (sh_control),
    .sh_data    (sh_data),
    .sh_result  (sh_result)
  );

  // Behavioural single-step shifter the sequencer drives.
  always_comb begin
    case (sh_control)
      2'b01:   sh_result = $unsigned($signed(sh_data) >>> 1);
      2'b10:   sh_result = sh_data << 8;
      default: sh_result = sh_data;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        op;
    logic [4:0]  amount;
    logic [31:0] data;
    logic [31:0] exp_result;
    int          exp_busy;
    int          exp_shifts;
  } vec_t;

  vec_t vecs[5];

  function automatic int refPasses(input logic op, input logic [4:0] amount);
    if (op) return int'(amount);
    return (int'(amount) > 4) ? 4 : int'(amount);
  endfunction

  function automatic logic [31:0] refResult(input logic op, input logic [4:0] amount,
                                            input logic [31:0] data);
    if (op) return $unsigned($signed(data) >>> amount);
    if (amount >= 5'd4) return 32'h0;
    return data << (8 * int'(amount));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one operation from IDLE; disturb_kind 1 pulses a competing start,
  // 2 asserts reset, in cycle disturb_cycle after the accepting edge.
  task automatic applyStimulus(input logic op, input logic [4:0] amount,
                               input logic [31:0] data, input int disturb_cycle,
                               input int disturb_kind,
                               output int busy_cnt, output int done_cnt,
                               output int shift_cnt, output int bad_ctrl,
                               output logic [31:0] done_result, output logic timed_out);
    logic [1:0] want_ctrl;
    want_ctrl   = op ? 2'b01 : 2'b10;
    busy_cnt    = 0;
    done_cnt    = 0;
    shift_cnt   = 0;
    bad_ctrl    = 0;
    done_result = 'x;
    timed_out   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.amount  = amount;
    bus.data_in = data;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op      = ~op;
    bus.amount  = 5'($urandom);
    bus.data_in = $urandom;
    for (int i = 0; i < 64; i++) begin
      if (i == disturb_cycle + 1) begin
        bus.start = 1'b0;
        reset     = 1'b0;
      end
      if (!bus.busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_result = bus.result;
      end
      if (sh_control == want_ctrl) shift_cnt++;
      else if (sh_control != 2'b00) bad_ctrl++;
      if (i == disturb_cycle && disturb_kind == 1) begin
        bus.start   = 1'b1;
        bus.op      = 1'b0;
        bus.amount  = 5'd1;
        bus.data_in = 32'hFFFF_FFFF;
      end
      if (i == disturb_cycle && disturb_kind == 2) reset = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    int busy_cnt, done_cnt, shift_cnt, bad_ctrl;
    logic [31:0] done_result;
    logic timed_out;
    applyStimulus(v.op, v.amount, v.data, -5, 0,
                  busy_cnt, done_cnt, shift_cnt, bad_ctrl, done_result, timed_out);
    checkOutput({v.name, "_timeout"}, 32'(timed_out), 32'd0);
    checkOutput({v.name, "_busy_cycles"}, busy_cnt, v.exp_busy);
    checkOutput({v.name, "_done_pulses"}, done_cnt, 32'd1);
    checkOutput({v.name, "_shift_cycles"}, shift_cnt, v.exp_shifts);
    checkOutput({v.name, "_bad_ctrl"}, bad_ctrl, 32'd0);
    checkOutput({v.name, "_done_result"}, done_result, v.exp_result);
    checkOutput({v.name, "_held_result"}, bus.result, v.exp_result);
  endtask

  initial begin
    int busy_cnt, done_cnt, shift_cnt, bad_ctrl;
    logic [31:0] done_result;
    logic timed_out;
    vec_t rv;

    compared   = 0;
    mismatched = 0;

    vecs[0] = '{"right4",  1'b1, 5'd4,  32'h8000_0000, 32'hF800_0000, 5,  4};
    vecs[1] = '{"left2",   1'b0, 5'd2,  32'h0000_00AB, 32'h00AB_0000, 3,  2};
    vecs[2] = '{"leftcap", 1'b0, 5'd7,  32'hFFFF_FFFF, 32'h0000_0000, 5,  4};
    vecs[3] = '{"zero",    1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1,  0};
    vecs[4] = '{"right10", 1'b1, 5'd10, 32'h4000_0000, 32'h0010_0000, 11, 10};

    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.op      = 1'b1;
    bus.amount  = 5'd3;
    bus.data_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_result", bus.result, 32'd0);
      checkOutput("reset_sh_control", 32'(sh_control), 32'd0);
    end
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) runVector(vecs[i]);

    // A competing start mid-operation must be ignored.
    applyStimulus(1'b1, 5'd10, 32'h4000_0000, 3, 1,
                  busy_cnt, done_cnt, shift_cnt, bad_ctrl, done_result, timed_out);
    checkOutput("ignore_timeout", 32'(timed_out), 32'd0);
    checkOutput("ignore_busy_cycles", busy_cnt, 32'd11);
    checkOutput("ignore_done_pulses", done_cnt, 32'd1);
    checkOutput("ignore_shift_cycles", shift_cnt, 32'd10);
    checkOutput("ignore_result", done_result, 32'h0010_0000);
    @(negedge clk);
    checkOutput("ignore_not_queued", 32'(bus.busy), 32'd0);

    // Reset mid-operation abandons the work without a done pulse.
    applyStimulus(1'b1, 5'd10, 32'h4000_0000, 5, 2,
                  busy_cnt, done_cnt, shift_cnt, bad_ctrl, done_result, timed_out);
    checkOutput("abort_timeout", 32'(timed_out), 32'd0);
    checkOutput("abort_busy_cycles", busy_cnt, 32'd6);
    checkOutput("abort_done_pulses", done_cnt, 32'd0);
    checkOutput("abort_result", bus.result, 32'd0);
    checkOutput("abort_sh_control", 32'(sh_control), 32'd0);

    // Held start: one acceptance every three cycles.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 1'b1;
    bus.amount  = 5'd1;
    bus.data_in = 32'h0000_0002;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("b2b_busy_%0d", i), 32'(bus.busy), 32'((i % 3) != 2));
      checkOutput($sformatf("b2b_done_%0d", i), 32'(bus.done), 32'((i % 3) == 1));
      if ((i % 3) == 1) checkOutput($sformatf("b2b_result_%0d", i), bus.result, 32'h1);
      if (i == 8) bus.start = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2b_stop", 32'(bus.busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      rv.name       = $sformatf("rand%0d", n);
      rv.op         = 1'($urandom);
      rv.amount     = 5'($urandom_range(0, 31));
      rv.data       = $urandom;
      rv.exp_result = refResult(rv.op, rv.amount, rv.data);
      rv.exp_shifts = refPasses(rv.op, rv.amount);
      rv.exp_busy   = rv.exp_shifts + 1;
      runVector(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
